m_seg_scan_driver: RTL and testbench
====================================

Name: m_seg_scan_driver

Overview:
Time-multiplexed driver for a common-anode multi-digit 7-segment display. It takes per-digit active-low segment patterns, as produced by the 7-segment decoder, and scans them onto one shared segment bus plus per-digit enables. A blanking gap between digits prevents ghosting. Frame data is snapshotted at frame start so a displayed frame never tears.

Parameters:
NDIG, 4, number of digits scanned (>=2)
PRESC, 12500, ON dwell per digit in clk cycles (>=1)
BLANK, 250, blank gap before each digit in clk cycles (>=1)

Ports:
clk  input  1  system clock
n_reset  input  1  asynchronous, active-low reset
en  input  1  scan enable; 0 = display dark
seg_in  input  8*NDIG  segment patterns, active-low {dp,g..a}; digit k at bits [8k+7:8k]
seg_out  output  8  shared segment bus, active-low; 8'hFF = all off
dig_out  output  NDIG  digit enables, active-low; bit k drives digit k
frame_start  output  1  one-cycle pulse when the frame snapshot is taken

Behaviour:
- Reset (async, n_reset=0): seg_out=8'hFF, dig_out=all 1, frame_start=0, state=IDLE, idx=0, cnt=0, frame buffer=all 8'hFF.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - IDLE: outputs off. Leave IDLE when en=1.
  - BLANK: dig_out all 1, seg_out=8'hFF, for exactly BLANK cycles (cnt 0..BLANK-1).
  - ON: dig_out[idx]=0, other bits 1, seg_out=buf[idx], for exactly PRESC cycles (cnt 0..PRESC-1).
- Transitions:
  - IDLE->BLANK with idx=0.
  - BLANK->ON when cnt=BLANK-1.
  - ON->BLANK when cnt=PRESC-1. In the same cycle idx increments, wrapping NDIG-1->0.
  - cnt clears on every state change.
- Snapshot: on every entry into BLANK with idx=0 (from IDLE or from wrap), all of seg_in is latched into buf. frame_start=1 during that first BLANK cycle only.
- Frame period = NDIG*(BLANK+PRESC) cycles. Frame_start pulses are exactly this far apart while en=1.
- en=0 in any state: next cycle is IDLE, outputs off, idx=0. On re-enable the scan restarts at digit 0 with a fresh snapshot and frame_start.
- seg_in changes mid-frame are not visible until the next snapshot.
- Invariant: at most one dig_out bit low in any cycle. seg_out=8'hFF whenever all dig_out bits are 1.
- Reset asserted mid-operation: outputs go off immediately, without waiting for a clock edge.
- Counter widths: cnt is $clog2(max(PRESC,BLANK)) bits, minimum 1. idx is $clog2(NDIG) bits, minimum 1.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, BLANK=2'd1, ON=2'd2
  - the segment all-off constant 8'hFF
  - a width helper function for counter sizing
- One sub-module: m_scan_timer, a parameterised dwell counter with load/clear and a terminal-count flag. It is instantiated once and reloaded with BLANK or PRESC on each state change.
- Frame buffer, idx and output registers stay in the top module.

Test Plan:
(All scenarios use NDIG=4, PRESC=3, BLANK=2; frame = 20 cycles.)
- Reset and en held 0 -> seg_out=8'hFF, dig_out=4'b1111, frame_start=0 on every cycle.
- en=1, seg_in={B0,A4,F9,C0} (d3..d0):
  - frame_start pulses, then 2 blank cycles, then dig_out=1110/seg=C0 for 3 cycles
  - 2 blank cycles, then 1101/F9 for 3 cycles
  - then 1011/A4, then 0111/B0, each preceded by 2 blank cycles
  - next frame_start exactly 20 cycles after the first
- Change d0 to 8'h99 during digit-2 ON -> digit 0 keeps showing C0 for the rest of this frame. It shows 99 only after the next frame_start.
- Drop en during digit-1 ON -> next cycle dig_out=1111, seg_out=FF. Re-raise en -> frame_start pulses, and the scan resumes at digit 0 after 2 blank cycles.
- Assert n_reset asynchronously mid-ON -> outputs go off before the next clk edge. After release, behaviour matches the first scenario.
- Continuous assertion over 1000 random-en cycles -> never more than one dig_out bit low. seg_out=FF whenever dig_out=1111.

Source files
------------

// File: rtl/m_seg_scan_driver_pkg.sv
//------------------------------------------------------------------------------
// Module   : m_seg_scan_driver_pkg
// Brief    : Shared state encoding, segment constants and counter sizing helper
//            for the multiplexed 7-segment scan driver.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package m_seg_scan_driver_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } scan_state_t;

    localparam logic [7:0] c_seg_off = 8'hFF;

    // Bits needed to count 0..max(a,b)-1, never less than one.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_scan_timer.sv
//------------------------------------------------------------------------------
// Module   : m_scan_timer
// Brief    : Dwell counter; load clears the count and latches a terminal value.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module m_scan_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_tc
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_q, lim_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        lim_d = lim_q;
        if (i_load) begin
            cnt_d = '0;
            lim_d = i_limit;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
            lim_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim_d;
        end
    end

    assign o_tc = (cnt_q == lim_q);

endmodule

`default_nettype wire

// File: rtl/m_seg_scan_driver.sv
//------------------------------------------------------------------------------
// Module   : m_seg_scan_driver
// Brief    : Time-multiplexed common-anode 7-segment scanner with blanking gaps
//            and per-frame snapshot of the segment patterns.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module m_seg_scan_driver
    import m_seg_scan_driver_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int PRESC = 12500,
    parameter int BLANK = 250
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              en,
    input  logic [8*NDIG-1:0] seg_in,
    output logic [7:0]        seg_out,
    output logic [NDIG-1:0]   dig_out,
    output logic              frame_start
);

    localparam int CNT_W = cnt_width(PRESC, BLANK);
    localparam int IDX_W = cnt_width(NDIG, NDIG);

    scan_state_t             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NDIG-1:0][7:0]    frame_buf_q, frame_buf_d;
    logic [7:0]              seg_out_q, seg_out_d;
    logic [NDIG-1:0]         dig_out_q, dig_out_d;
    logic                    frame_start_q, frame_start_d;

    logic                    tmr_load;
    logic [CNT_W-1:0]        tmr_limit;
    logic                    tmr_tc;
    logic                    snap;

    m_scan_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk     (clk),
        .n_reset (n_reset),
        .i_load  (tmr_load),
        .i_limit (tmr_limit),
        .o_tc    (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_BLANK;
                idx_d   = '0;
            end
            S_BLANK: begin
                if (tmr_tc) begin
                    state_d = S_ON;
                end
            end
            S_ON: begin
                if (tmr_tc) begin
                    state_d = S_BLANK;
                    idx_d   = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        if (!en) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end

        // A frame begins whenever the scan (re)enters the blank ahead of digit 0.
        snap          = (state_d == S_BLANK) && (state_q != S_BLANK) && (idx_d == '0);
        frame_buf_d   = snap ? seg_in : frame_buf_q;
        frame_start_d = snap;

        tmr_load  = (state_d != state_q) || (state_q == S_IDLE);
        tmr_limit = (state_d == S_ON) ? CNT_W'(PRESC - 1) : CNT_W'(BLANK - 1);

        // Outputs are derived from next-state values so they register in step with the FSM.
        seg_out_d = c_seg_off;
        dig_out_d = '1;
        if (state_d == S_ON) begin
            seg_out_d        = frame_buf_d[idx_d];
            dig_out_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            frame_buf_q   <= {NDIG{c_seg_off}};
            seg_out_q     <= c_seg_off;
            dig_out_q     <= '1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            frame_buf_q   <= frame_buf_d;
            seg_out_q     <= seg_out_d;
            dig_out_q     <= dig_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_out     = seg_out_q;
    assign dig_out     = dig_out_q;
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_m_seg_scan_driver.sv
//------------------------------------------------------------------------------
// Module   : tb_m_seg_scan_driver
// Brief    : Directed self-checking bench for the 7-segment scan driver.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_m_seg_scan_driver;

    localparam int NDIG  = 4;
    localparam int PRESC = 3;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * (PRESC + BLANK);

    logic        clk = 1'b0;
    logic        n_reset;
    logic        en;
    logic [31:0] seg_in;
    logic [7:0]  seg_out;
    logic [3:0]  dig_out;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    m_seg_scan_driver #(
        .NDIG  (NDIG),
        .PRESC (PRESC),
        .BLANK (BLANK)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .en          (en),
        .seg_in      (seg_in),
        .seg_out     (seg_out),
        .dig_out     (dig_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_off(input string tag);
        check_eq({tag, "_fs"},  {31'd0, frame_start}, 32'd0);
        check_eq({tag, "_dig"}, {28'd0, dig_out},     32'hF);
        check_eq({tag, "_seg"}, {24'd0, seg_out},     32'hFF);
    endtask

    // Walks ncyc cycles of a frame, starting from its frame_start cycle.
    task automatic run_frame(input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input int ncyc, input int chg_cyc, input logic [31:0] chg_val);
        logic [7:0] ex [4];
        logic [3:0] exp_dig;
        logic [7:0] exp_seg;
        logic       exp_fs;
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        for (int c = 0; c < ncyc; c++) begin
            int d;
            int ph;
            @(posedge clk);
            @(negedge clk);
            d  = c / (PRESC + BLANK);
            ph = c % (PRESC + BLANK);
            exp_fs  = (c == 0);
            exp_dig = 4'hF;
            exp_seg = 8'hFF;
            if (ph >= BLANK) begin
                exp_dig[d] = 1'b0;
                exp_seg    = ex[d];
            end
            check_eq($sformatf("frame_c%0d_fs", c),  {31'd0, frame_start}, {31'd0, exp_fs});
            check_eq($sformatf("frame_c%0d_dig", c), {28'd0, dig_out},     {28'd0, exp_dig});
            check_eq($sformatf("frame_c%0d_seg", c), {24'd0, seg_out},     {24'd0, exp_seg});
            if (c == chg_cyc) seg_in = chg_val;
        end
    endtask

    initial begin
        n_reset = 1'b0;
        en      = 1'b0;
        seg_in  = 32'hB0A4F9C0;

        repeat (3) begin
            @(negedge clk);
            check_off("reset");
        end
        n_reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_off("idle_en0");
        end

        // Basic scan, two back-to-back frames; d0 changes during digit-2 ON of the second.
        en = 1'b1;
        run_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0, FRAME, -1, 32'd0);
        run_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0, FRAME, 12, 32'hB0A4F999);
        run_frame(8'h99, 8'hF9, 8'hA4, 8'hB0, FRAME, -1, 32'd0);

        // Drop en on the first ON cycle of digit 1, then restart.
        run_frame(8'h99, 8'hF9, 8'hA4, 8'hB0, 8, -1, 32'd0);
        en = 1'b0;
        @(negedge clk);
        check_off("en_drop");
        en = 1'b1;
        run_frame(8'h99, 8'hF9, 8'hA4, 8'hB0, FRAME, -1, 32'd0);

        // Asynchronous reset during digit-0 ON, checked before the next rising edge.
        run_frame(8'h99, 8'hF9, 8'hA4, 8'hB0, 4, -1, 32'd0);
        #2 n_reset = 1'b0;
        #1 check_off("async_rst");
        seg_in = 32'hB0A4F9C0;
        @(negedge clk);
        check_off("rst_held");
        n_reset = 1'b1;
        run_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0, FRAME, -1, 32'd0);

        // Random enable toggling with invariant checks.
        repeat (1000) begin
            if ($urandom_range(0, 7) == 0) en = ~en;
            @(negedge clk);
            check_eq("inv_onehot", {31'd0, ($countones(~dig_out) <= 1)}, 32'd1);
            check_eq("inv_blank_seg", {31'd0, ((dig_out != 4'hF) || (seg_out == 8'hFF))}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
